// File: rtl/control_fifo.sv
// control_fifo: pointer and status controller for a FIFO register bank.
// Drives the bank's write enable and write/read addresses. Keeps registered
// occupancy, full/empty/almost flags and sticky overflow/underflow flags.
// Read data is first-word-fall-through from the bank's asynchronous read port.
module control_fifo #(
  parameter int A        = 4,
  parameter int AF_LEVEL = 2**A - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  output logic         wr_en,
  output logic [A-1:0] address_w,
  output logic [A-1:0] address_r,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [A:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [A:0] DEPTH = (A+1)'(2**A);
  localparam logic [A:0] AF_LV = (A+1)'(AF_LEVEL);
  localparam logic [A:0] AE_LV = (A+1)'(AE_LEVEL);

  logic [A-1:0] wp_q, wp_d;
  logic [A-1:0] rp_q, rp_d;
  logic [A:0]   count_q, count_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  logic         af_q, af_d;
  logic         ae_q, ae_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         rd_ok, wr_ok;

  // Acceptance, bank write enable and next-state for pointers, count and flags.
  // A push into a full FIFO succeeds only alongside an accepted pop; a pop on
  // an empty FIFO is always rejected, even if a push lands in the same cycle.
  // Flags are computed from the next count so they change with the pointers.
  always_comb begin
    rd_ok   = rd & ~empty_q;
    wr_ok   = wr & (~full_q | rd_ok);
    wr_en   = wr_ok & ~reset;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (wr_ok) wp_d = wp_q + A'(1);
    if (rd_ok) rp_d = rp_q + A'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (A+1)'(1);
      2'b01:   count_d = count_q - (A+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_LV);
    ae_d    = (count_d <= AE_LV);
    ovf_d   = ovf_q | (wr & ~wr_ok);
    unf_d   = unf_q | (rd & ~rd_ok);
  end

  // State register; reset wins over any request presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LV == '0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign address_w    = wp_q;
  assign address_r    = rp_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_control_fifo.sv
// tb_control_fifo: directed vector table plus randomized traffic against a
// queue-based reference model, with a small register bank for data_out.
module tb_control_fifo;

  localparam int A  = 2;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr, rd;
  logic [7:0]   din;
  logic         wr_en;
  logic [A-1:0] address_w, address_r;
  logic         full, empty, almost_full, almost_empty;
  logic [A:0]   count;
  logic         overflow, underflow;

  logic [7:0]   bank [D];
  logic [7:0]   dataOut;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [7:0] q[$];
  int  pushes, pops;
  bit  mOvf, mUnf;

  control_fifo #(.A(A), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .wr_en(wr_en),
    .address_w(address_w), .address_r(address_r), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Register bank the controller addresses; asynchronous read.
  always @(posedge clk) if (wr_en) bank[address_w] <= din;
  assign dataOut = bank[address_r];

  typedef struct {
    bit       w, r;
    bit [7:0] d;
    bit       eWrEn;
    int       eCount, eWp, eRp;
    bit       eFull, eEmpty, eAf, eAe, eOvf, eUnf;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkModel();
    int n = q.size();
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("full", 32'(full), 32'(n == D));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(n >= AF));
    checkOutput("almost_empty", 32'(almost_empty), 32'(n <= AE));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
    checkOutput("underflow", 32'(underflow), 32'(mUnf));
    checkOutput("address_w", 32'(address_w), 32'(pushes % D));
    checkOutput("address_r", 32'(address_r), 32'(pops % D));
    if (n > 0) checkOutput("head", 32'(dataOut), 32'(q[0]));
  endtask

  // One clock cycle of traffic; returns the wr_en seen before the edge.
  task automatic applyStimulus(input bit w, input bit r, input bit [7:0] d, output bit wrEnSeen);
    bit rdOk, wrOk;
    wr = w; rd = r; din = d;
    #1;
    rdOk = r && (q.size() > 0);
    wrOk = w && ((q.size() < D) || rdOk);
    wrEnSeen = wr_en;
    checkOutput("wr_en", 32'(wr_en), 32'(wrOk));
    @(posedge clk);
    if (rdOk) begin void'(q.pop_front()); pops++; end
    if (wrOk) begin q.push_back(d); pushes++; end
    if (w && !wrOk) mOvf = 1'b1;
    if (r && !rdOk) mUnf = 1'b1;
    #1;
    checkModel();
  endtask

  task automatic applyReset(input bit w, input bit r);
    reset = 1'b1; wr = w; rd = r; din = 8'hEE;
    #1;
    checkOutput("wr_en_in_reset", 32'(wr_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0; rd = 1'b0;
    q.delete(); pushes = 0; pops = 0; mOvf = 1'b0; mUnf = 1'b0;
    checkModel();
  endtask

  vec_t vecs[$];
  bit   seen;

  initial begin
    // w r data   wrEn cnt wp rp full empty af ae ovf unf
    vecs.push_back('{1,0,8'h11, 1, 1,1,0, 0,0,0,1, 0,0});
    vecs.push_back('{1,0,8'h22, 1, 2,2,0, 0,0,0,0, 0,0});
    vecs.push_back('{1,0,8'h33, 1, 3,3,0, 0,0,1,0, 0,0});
    vecs.push_back('{1,0,8'h44, 1, 4,0,0, 1,0,1,0, 0,0});
    vecs.push_back('{1,0,8'h55, 0, 4,0,0, 1,0,1,0, 1,0});
    vecs.push_back('{1,1,8'h66, 1, 4,1,1, 1,0,1,0, 1,0});
    vecs.push_back('{1,1,8'h77, 1, 4,2,2, 1,0,1,0, 1,0});
    vecs.push_back('{1,1,8'h88, 1, 4,3,3, 1,0,1,0, 1,0});
    vecs.push_back('{1,1,8'h99, 1, 4,0,0, 1,0,1,0, 1,0});
    vecs.push_back('{0,1,8'h00, 0, 3,0,1, 0,0,1,0, 1,0});
    vecs.push_back('{0,1,8'h00, 0, 2,0,2, 0,0,0,0, 1,0});
    vecs.push_back('{0,1,8'h00, 0, 1,0,3, 0,0,0,1, 1,0});
    vecs.push_back('{0,1,8'h00, 0, 0,0,0, 0,1,0,1, 1,0});
    vecs.push_back('{0,1,8'h00, 0, 0,0,0, 0,1,0,1, 1,1});
    vecs.push_back('{1,1,8'hAA, 1, 1,1,0, 0,0,0,1, 1,1});

    reset = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
    q.delete(); pushes = 0; pops = 0; mOvf = 1'b0; mUnf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkModel();

    // directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].w, vecs[i].r, vecs[i].d, seen);
      checkOutput($sformatf("vec%0d_wr_en", i), 32'(seen), 32'(vecs[i].eWrEn));
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].eCount));
      checkOutput($sformatf("vec%0d_wp", i), 32'(address_w), 32'(vecs[i].eWp));
      checkOutput($sformatf("vec%0d_rp", i), 32'(address_r), 32'(vecs[i].eRp));
      checkOutput($sformatf("vec%0d_flags", i),
                  {26'd0, full, empty, almost_full, almost_empty, overflow, underflow},
                  {26'd0, vecs[i].eFull, vecs[i].eEmpty, vecs[i].eAf, vecs[i].eAe,
                   vecs[i].eOvf, vecs[i].eUnf});
      if (i == 0) checkOutput("vec0_head", 32'(dataOut), 32'h11);
    end

    // mid-operation reset at count 3 with push and pop requested
    applyStimulus(1'b1, 1'b0, 8'hBB, seen);
    applyStimulus(1'b1, 1'b0, 8'hCC, seen);
    checkOutput("pre_reset_count", 32'(count), 32'd3);
    applyReset(1'b1, 1'b1);
    checkOutput("post_reset_count", 32'(count), 32'd0);
    checkOutput("post_reset_flags", {28'd0, overflow, underflow, empty, almost_empty},
                {28'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    applyStimulus(1'b1, 1'b0, 8'h5A, seen);
    checkOutput("first_after_reset", 32'(count), 32'd1);
    checkOutput("first_after_reset_head", 32'(dataOut), 32'h5A);

    // randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0)
        applyReset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_fifo.md
# control_fifo

Pointer and status controller for the FIFO queue, sitting on the address side of the FIFO's register bank. It accepts push (`wr`) and pop (`rd`) requests from the producer and consumer. It drives the bank's write enable, write address and read address, and keeps full/empty/occupancy status. Read data comes from the bank's asynchronous read port and is first-word-fall-through: the head word is valid whenever `empty` is 0.

## Interface
- `A`, default 4, address bits; depth D = 2**A words.
- `AF_LEVEL`, default 2**A-2, `almost_full` asserts when occupancy >= AF_LEVEL.
- `AE_LEVEL`, default 2, `almost_empty` asserts when occupancy <= AE_LEVEL.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr`  in  1  push request; data is presented to the bank's `data_in` in the same cycle.
- `rd`  in  1  pop request; consumes the current head word.
- `wr_en`  out  1  bank write enable (combinational).
- `address_w`  out  A  bank write address, equal to the write pointer.
- `address_r`  out  A  bank read address, equal to the read pointer.
- `full`  out  1  occupancy == D.
- `empty`  out  1  occupancy == 0.
- `almost_full`  out  1  occupancy >= AF_LEVEL.
- `almost_empty`  out  1  occupancy <= AE_LEVEL.
- `count`  out  A+1  occupancy, 0..D.
- `overflow`  out  1  sticky; a push was rejected.
- `underflow`  out  1  sticky; a pop was rejected.

## Operation
- **State:** write pointer `wp` (A bits), read pointer `rp` (A bits) and `count` (A+1 bits), all registered.
  - `full`, `empty`, `almost_full` and `almost_empty` are registered and derived from the next value of `count`.
  - `address_w` = `wp`; `address_r` = `rp`.
- **Acceptance:**
  - `rd_ok` = `rd` & !`empty`.
  - `wr_ok` = `wr` & (!`full` | `rd_ok`). A push into a full FIFO is accepted only if a pop is accepted in the same cycle.
  - On an empty FIFO with `wr` = `rd` = 1, only the write is accepted. The pop is rejected and `underflow` sets.
- **Bank write:** `wr_en` = `wr_ok`, combinational from inputs and registered flags.
- **Pointer and count update per edge:**
  - `wr_ok` only: `wp`+1, `count`+1.
  - `rd_ok` only: `rp`+1, `count`-1.
  - Both: `wp`+1, `rp`+1, `count` unchanged.
  - Neither: hold.
- **Wrap-around:** pointers increment modulo D (natural A-bit rollover). `count` never leaves 0..D.
- **Error flags:**
  - `wr` & !`wr_ok` sets `overflow`.
  - `rd` & !`rd_ok` sets `underflow`.
  - Both clear only on `reset`.
- **Head data:** the bank `data_out` is the head word while `empty` = 0. It is undefined while `empty` = 1.
- **Reset:** has priority over `wr` and `rd` in the same cycle; requests in the reset cycle are ignored. Stored data is not cleared but becomes unreachable.

## Timing
- **Reset values:** `wp` = `rp` = 0, `count` = 0, `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0, `overflow` = `underflow` = 0. `wr_en` = 0 while `wr` = 0.
- **Write-to-read latency:** one cycle. A word pushed at edge N is readable at `data_out`, with `empty` = 0, after edge N.
- **Status updates:** `count` and all flags update at the same edge as the pointers. No combinational path from `rd`/`wr` to the status outputs.
- **Mid-operation reset:** a `reset` asserted in any state returns to the reset values at that edge. The first request is honoured in the cycle after `reset` deasserts.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles (A = 2) -> `count` 1,2,3; `empty` falls after first edge; `address_w` 1,2,3; `data_out` = 0x11 while `address_r` = 0.
- Fill to 4 words, push again with `rd` = 0 -> `full` = 1, `wr_en` = 0, `count` stays 4, `overflow` = 1; then push+pop while full -> both accepted, `wp` and `rp` wrap 3->0, `count` = 4.
- Drain 4 words, then pop on empty -> `empty` = 1, `rp` unchanged, `underflow` = 1; push+pop on empty -> only the write occurs, `count` = 1.
- Run 10 push/pop cycles with random data -> pointers wrap at least twice; popped order equals pushed order; `count` matches a reference model every cycle.
- With AF_LEVEL = 3 and AE_LEVEL = 1, step `count` 0->4->0 -> `almost_full` = 1 exactly at `count` 3,4; `almost_empty` = 1 exactly at `count` 0,1.
- Assert `reset` with `count` = 3 and `wr` = `rd` = 1 -> next cycle all outputs at reset values, `wr_en` effect suppressed, flags cleared.
